trap_wave_sched: RTL and testbench

Scheduler and configurator for the trapezoid/triangle waveform datapath. It holds a small table of waveform profiles (peak, flat-top hold, inter-period gap) and accepts play commands through a valid/ready handshake. Each command runs a selected profile for a requested number of periods and drives the 9-bit sample output. It sits between the control/register side and the DAC sample path, and supports graceful abort (ramp down, then stop).

---
 rtl/trap_wave_sched_pkg.sv | 27 ++
 rtl/trap_wave_sched_if.sv | 29 ++
 rtl/trap_wave_sched_prof_regs.sv | 39 +++
 rtl/trap_wave_sched.sv | 201 ++++++++++++++++++++
 tb/tb_trap_wave_sched.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/trap_wave_sched_pkg.sv
// Shared definitions for the trapezoid/triangle waveform scheduler:
// state encodings, default widths and the profile record layout.
package trap_sched_pkg;

    localparam int DW_DEF    = 9;
    localparam int HW_DEF    = 9;
    localparam int NPROF_DEF = 4;
    localparam int IW_DEF    = 2;
    localparam int RW_DEF    = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RISE = 3'd1,
        HOLD = 3'd2,
        FALL = 3'd3,
        GAP  = 3'd4
    } state_e;

    typedef struct packed {
        logic [DW_DEF-1:0] peak;
        logic [HW_DEF-1:0] hold;
        logic [HW_DEF-1:0] gap;
    } prof_t;

    localparam int PROF_W = $bits(prof_t);

endpackage

// File: rtl/trap_wave_sched_if.sv
// Configuration and play-command bus between the control side and the scheduler.
interface trap_wave_sched_if #(
    parameter int DW = trap_sched_pkg::DW_DEF,
    parameter int HW = trap_sched_pkg::HW_DEF,
    parameter int IW = trap_sched_pkg::IW_DEF,
    parameter int RW = trap_sched_pkg::RW_DEF
) ();
    logic          cfg_we;
    logic [IW-1:0] cfg_idx;
    logic [DW-1:0] cfg_peak;
    logic [HW-1:0] cfg_hold;
    logic [HW-1:0] cfg_gap;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [IW-1:0] cmd_idx;
    logic [RW-1:0] cmd_rpt;

    modport master (
        output cfg_we, cfg_idx, cfg_peak, cfg_hold, cfg_gap,
        output cmd_valid, cmd_idx, cmd_rpt,
        input  cmd_ready
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_peak, cfg_hold, cfg_gap,
        input  cmd_valid, cmd_idx, cmd_rpt,
        output cmd_ready
    );
endinterface

// File: rtl/trap_wave_sched_prof_regs.sv
// Profile table: synchronous write, combinational read, cleared by reset.
module trap_prof_regs
    import trap_sched_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int HW    = HW_DEF,
    parameter int NPROF = NPROF_DEF,
    parameter int IW    = IW_DEF
) (
    input  logic          clk,
    input  logic          res,
    input  logic          we,
    input  logic [IW-1:0] widx,
    input  logic [DW-1:0] wpeak,
    input  logic [HW-1:0] whold,
    input  logic [HW-1:0] wgap,
    input  logic [IW-1:0] ridx,
    output logic [DW-1:0] rpeak,
    output logic [HW-1:0] rhold,
    output logic [HW-1:0] rgap
);
    localparam int EW = DW + 2 * HW;

    logic [EW-1:0] mem_r [NPROF];

    // Entry storage; a same-cycle reader still sees the previous contents.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int i = 0; i < NPROF; i++) begin
                mem_r[i] <= '0;
            end
        end else if (we) begin
            mem_r[widx] <= {wpeak, whold, wgap};
        end
    end

    assign {rpeak, rhold, rgap} = mem_r[ridx];

endmodule

// File: rtl/trap_wave_sched.sv
// Plays a selected trapezoid profile for cmd_rpt+1 periods on d_out,
// with abort that ramps down from the current level before stopping.
module trap_wave_sched
    import trap_sched_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int HW    = HW_DEF,
    parameter int NPROF = NPROF_DEF,
    parameter int IW    = IW_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic          clk,
    input  logic          res,
    trap_wave_sched_if.slave bus,
    input  logic          abort,
    output logic [DW-1:0] d_out,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [2:0]    phase
);
    localparam logic [DW-1:0] D_ONE = {{(DW-1){1'b0}}, 1'b1};

    state_e        state_r, state_s;
    logic [DW-1:0] d_out_r, d_out_s, peak_r, peak_s, rd_peak;
    logic [HW-1:0] hcnt_r, hcnt_s, gcnt_r, gcnt_s;
    logic [HW-1:0] hold_r, hold_s, gap_r, gap_s, rd_hold, rd_gap;
    logic [RW-1:0] rpt_r, rpt_s;
    logic          abrt_r, abrt_s, done_r, done_s, aborted_r, aborted_s;
    logic          accept_s, end_s;

    trap_prof_regs #(.DW(DW), .HW(HW), .NPROF(NPROF), .IW(IW)) u_prof (
        .clk   (clk),
        .res   (res),
        .we    (bus.cfg_we),
        .widx  (bus.cfg_idx),
        .wpeak (bus.cfg_peak),
        .whold (bus.cfg_hold),
        .wgap  (bus.cfg_gap),
        .ridx  (bus.cmd_idx),
        .rpeak (rd_peak),
        .rhold (rd_hold),
        .rgap  (rd_gap)
    );

    assign accept_s = bus.cmd_valid & (state_r == IDLE);

    // Next-state, sample and counter computation.
    always_comb begin
        state_s   = state_r;
        d_out_s   = d_out_r;
        hcnt_s    = hcnt_r;
        gcnt_s    = gcnt_r;
        rpt_s     = rpt_r;
        peak_s    = peak_r;
        hold_s    = hold_r;
        gap_s     = gap_r;
        abrt_s    = abrt_r;
        done_s    = 1'b0;
        aborted_s = 1'b0;
        end_s     = 1'b0;
        case (state_r)
            IDLE: begin
                d_out_s = '0;
                hcnt_s  = '0;
                gcnt_s  = '0;
                abrt_s  = 1'b0;
                if (accept_s) begin
                    state_s = RISE;
                    rpt_s   = bus.cmd_rpt;
                    peak_s  = (rd_peak == '0) ? D_ONE : rd_peak;
                    hold_s  = rd_hold;
                    gap_s   = rd_gap;
                end else begin
                    state_s = IDLE;
                end
            end
            RISE: begin
                if (abort) begin
                    rpt_s  = '0;
                    abrt_s = 1'b1;
                    if (d_out_r == '0) begin
                        end_s = 1'b1;
                    end else begin
                        state_s = FALL;
                    end
                end else begin
                    d_out_s = d_out_r + D_ONE;
                    if (d_out_r == peak_r - D_ONE) begin
                        state_s = (hold_r == '0) ? FALL : HOLD;
                    end else begin
                        state_s = RISE;
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    rpt_s   = '0;
                    abrt_s  = 1'b1;
                    hcnt_s  = '0;
                    state_s = FALL;
                end else if (hcnt_r == hold_r - {{(HW-1){1'b0}}, 1'b1}) begin
                    hcnt_s  = '0;
                    state_s = FALL;
                end else begin
                    hcnt_s  = hcnt_r + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            FALL: begin
                if (abort) begin
                    rpt_s  = '0;
                    abrt_s = 1'b1;
                end else begin
                    abrt_s = abrt_r;
                end
                // An aborted run skips the gap and stops right after the ramp.
                if (d_out_r <= D_ONE) begin
                    d_out_s = '0;
                    if ((gap_r == '0) || abrt_s) begin
                        end_s = 1'b1;
                    end else begin
                        state_s = GAP;
                    end
                end else begin
                    d_out_s = d_out_r - D_ONE;
                end
            end
            GAP: begin
                d_out_s = '0;
                if (abort) begin
                    rpt_s  = '0;
                    abrt_s = 1'b1;
                    gcnt_s = '0;
                    end_s  = 1'b1;
                end else if (gcnt_r == gap_r - {{(HW-1){1'b0}}, 1'b1}) begin
                    gcnt_s = '0;
                    end_s  = 1'b1;
                end else begin
                    gcnt_s = gcnt_r + {{(HW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s = IDLE;
                d_out_s = '0;
                hcnt_s  = '0;
                gcnt_s  = '0;
                rpt_s   = '0;
                abrt_s  = 1'b0;
            end
        endcase
        if (end_s) begin
            if (rpt_s != '0) begin
                rpt_s   = rpt_s - {{(RW-1){1'b0}}, 1'b1};
                state_s = RISE;
            end else begin
                state_s   = IDLE;
                done_s    = 1'b1;
                aborted_s = abrt_s;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // State, datapath and status registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (res) begin
            state_r   <= IDLE;
            d_out_r   <= '0;
            hcnt_r    <= '0;
            gcnt_r    <= '0;
            rpt_r     <= '0;
            peak_r    <= '0;
            hold_r    <= '0;
            gap_r     <= '0;
            abrt_r    <= 1'b0;
            done_r    <= 1'b0;
            aborted_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            d_out_r   <= d_out_s;
            hcnt_r    <= hcnt_s;
            gcnt_r    <= gcnt_s;
            rpt_r     <= rpt_s;
            peak_r    <= peak_s;
            hold_r    <= hold_s;
            gap_r     <= gap_s;
            abrt_r    <= abrt_s;
            done_r    <= done_s;
            aborted_r <= aborted_s;
        end
    end

    assign d_out         = d_out_r;
    assign busy          = (state_r != IDLE);
    assign done          = done_r;
    assign aborted       = aborted_r;
    assign phase         = state_r;
    assign bus.cmd_ready = (state_r == IDLE);

endmodule

// File: tb/tb_trap_wave_sched.sv
// Randomized bench for trap_wave_sched: each play command is expanded into its
// expected sample list from the profile rules, then compared cycle by cycle.
module tb_trap_wave_sched;
    import trap_sched_pkg::*;

    localparam int SEG_R = 0, SEG_H = 1, SEG_F = 2, SEG_G = 3;

    logic              clk = 1'b0;
    logic              res;
    logic              abort;
    logic [DW_DEF-1:0] d_out;
    logic              busy, done, aborted;
    logic [2:0]        phase;

    int n_cmp = 0;
    int n_err = 0;
    int m_peak [NPROF_DEF];
    int m_hold [NPROF_DEF];
    int m_gap  [NPROF_DEF];
    int q_val [$];
    int q_seg [$];

    trap_wave_sched_if bus ();

    trap_wave_sched dut (
        .clk     (clk),
        .res     (res),
        .bus     (bus),
        .abort   (abort),
        .d_out   (d_out),
        .busy    (busy),
        .done    (done),
        .aborted (aborted),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int pk, input int hd, input int gp);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = IW_DEF'(idx);
        bus.cfg_peak = DW_DEF'(pk);
        bus.cfg_hold = HW_DEF'(hd);
        bus.cfg_gap  = HW_DEF'(gp);
        tick();
        bus.cfg_we   = 1'b0;
        m_peak[idx] = pk;
        m_hold[idx] = hd;
        m_gap[idx]  = gp;
    endtask

    // Expected samples: per period ramp 0..p-1, p held 'hold' times, p..1, then 'gap' zeros.
    function automatic void build(input int idx, input int rpt);
        int p;
        q_val.delete();
        q_seg.delete();
        p = (m_peak[idx] == 0) ? 1 : m_peak[idx];
        for (int r = 0; r <= rpt; r++) begin
            for (int i = 0; i < p; i++) begin q_val.push_back(i); q_seg.push_back(SEG_R); end
            for (int i = 0; i < m_hold[idx]; i++) begin q_val.push_back(p); q_seg.push_back(SEG_H); end
            for (int i = p; i >= 1; i--) begin q_val.push_back(i); q_seg.push_back(SEG_F); end
            for (int i = 0; i < m_gap[idx]; i++) begin q_val.push_back(0); q_seg.push_back(SEG_G); end
        end
    endfunction

    // Abort seen while sample k is shown: keep samples up to k, then ramp down and stop.
    function automatic void cut_at(input int k);
        int v, s;
        v = q_val[k];
        s = q_seg[k];
        while (q_val.size() > k + 1) begin
            void'(q_val.pop_back());
            void'(q_seg.pop_back());
        end
        if ((s == SEG_R && v > 0) || s == SEG_H) begin
            for (int i = v; i >= 1; i--) begin q_val.push_back(i); q_seg.push_back(SEG_F); end
        end else if (s == SEG_F) begin
            for (int i = v - 1; i >= 1; i--) begin q_val.push_back(i); q_seg.push_back(SEG_F); end
        end
    endfunction

    task automatic run_cmd(input int idx, input int rpt, input int abort_at, input bit wr_same,
                           input bit wr_mid, input bit idle_ab, input int res_at);
        int w, c, k, np, nh, ng;
        bit exp_ab;
        w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        build(idx, rpt);
        k = abort_at;
        if (abort_at == -2) k = int'($urandom_range(0, q_val.size() - 1));
        exp_ab = 1'b0;
        np = int'($urandom_range(0, 15));
        nh = int'($urandom_range(0, 4));
        ng = int'($urandom_range(0, 3));
        bus.cmd_valid = 1'b1;
        bus.cmd_idx   = IW_DEF'(idx);
        bus.cmd_rpt   = RW_DEF'(rpt);
        abort         = idle_ab;
        if (wr_same) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_idx  = IW_DEF'(idx);
            bus.cfg_peak = DW_DEF'(np);
            bus.cfg_hold = HW_DEF'(nh);
            bus.cfg_gap  = HW_DEF'(ng);
        end
        tick();
        bus.cmd_valid = 1'b0;
        bus.cfg_we    = 1'b0;
        abort         = 1'b0;
        if (wr_same) begin
            m_peak[idx] = np; m_hold[idx] = nh; m_gap[idx] = ng;
        end
        c = 0;
        while (c < q_val.size() && c < 4000) begin
            chk("d_out", 32'(d_out), q_val[c]);
            chk("busy_run", 32'(busy), 32'd1);
            chk("done_run", 32'(done), 32'd0);
            bus.cfg_we = 1'b0;
            abort      = 1'b0;
            if (c == k) begin
                abort  = 1'b1;
                cut_at(c);
                exp_ab = 1'b1;
            end
            if (wr_mid && c == 2) begin
                np = int'($urandom_range(0, 15));
                nh = int'($urandom_range(0, 4));
                ng = int'($urandom_range(0, 3));
                bus.cfg_we   = 1'b1;
                bus.cfg_idx  = IW_DEF'(idx);
                bus.cfg_peak = DW_DEF'(np);
                bus.cfg_hold = HW_DEF'(nh);
                bus.cfg_gap  = HW_DEF'(ng);
                m_peak[idx] = np; m_hold[idx] = nh; m_gap[idx] = ng;
            end
            if (c == res_at) begin
                res = 1'b1;
                tick();
                res = 1'b0;
                abort = 1'b0;
                bus.cfg_we = 1'b0;
                chk("rst_d_out", 32'(d_out), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_aborted", 32'(aborted), 32'd0);
                chk("rst_phase", 32'(phase), 32'd0);
                chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
                for (int i = 0; i < NPROF_DEF; i++) begin
                    m_peak[i] = 0; m_hold[i] = 0; m_gap[i] = 0;
                end
                return;
            end
            tick();
            c++;
        end
        bus.cfg_we = 1'b0;
        abort      = 1'b0;
        chk("done_end", 32'(done), 32'd1);
        chk("aborted_end", 32'(aborted), 32'(exp_ab));
        chk("d_out_end", 32'(d_out), 32'd0);
        chk("ready_end", 32'(bus.cmd_ready), 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        tick();
        chk("done_pulse", 32'(done), 32'd0);
    endtask

    initial begin
        res = 1'b1;
        abort = 1'b0;
        bus.cfg_we = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_peak = '0;
        bus.cfg_hold = '0;
        bus.cfg_gap = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_idx = '0;
        bus.cmd_rpt = '0;
        for (int i = 0; i < NPROF_DEF; i++) begin
            m_peak[i] = 0; m_hold[i] = 0; m_gap[i] = 0;
        end
        tick();
        tick();
        chk("init_d_out", 32'(d_out), 32'd0);
        chk("init_busy", 32'(busy), 32'd0);
        chk("init_done", 32'(done), 32'd0);
        chk("init_phase", 32'(phase), 32'd0);
        chk("init_ready", 32'(bus.cmd_ready), 32'd1);
        res = 1'b0;
        tick();

        cfg_write(0, 4, 2, 1);   run_cmd(0, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(0, 4, 0, 0);   run_cmd(0, 2, -1, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(2, 0, 1, 1);   run_cmd(2, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(3, 6, 3, 2);   run_cmd(3, 3, 2, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(2, 3, 4, 2);   run_cmd(2, 1, 4, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(2, 2, 0, 3);   run_cmd(2, 1, 5, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(2, 2, 0, 0);   run_cmd(2, 2, 4, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(1, 5, 1, 2);   run_cmd(1, 1, -1, 1'b1, 1'b1, 1'b1, -1);
        run_cmd(1, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(0, 2, 511, 3); run_cmd(0, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(0, 1, 0, 511); run_cmd(0, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        cfg_write(0, 511, 0, 0); run_cmd(0, 0, -1, 1'b0, 1'b0, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1)
                cfg_write(int'($urandom_range(0, NPROF_DEF - 1)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
            run_cmd(int'($urandom_range(0, NPROF_DEF - 1)), int'($urandom_range(0, 3)),
                    ($urandom_range(0, 2) == 0) ? -2 : -1,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);
        end

        cfg_write(1, 300, 20, 0);
        cfg_write(2, 7, 1, 1);
        run_cmd(1, 0, -1, 1'b0, 1'b0, 1'b0, 305);
        run_cmd(1, 0, -1, 1'b0, 1'b0, 1'b0, -1);
        run_cmd(2, 1, -1, 1'b0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
